// File: rtl/fft_cbfp_pkg.sv
// fft_cbfp_pkg: shared widths and types for the CBFP scale-factor scheduler
package fft_cbfp_pkg;
  localparam int SF_W = 5;
  localparam int NBLK = 32;
  localparam int BEATS1 = 8;
  typedef logic [SF_W-1:0] sf_t;
  typedef logic [SF_W:0] sf_total_t;
  typedef logic [$clog2(NBLK)-1:0] idx_t;
  typedef logic [$clog2(BEATS1)-1:0] beat_t;
  typedef logic bank_t;
endpackage

// File: rtl/sf_bank_ram.sv
// sf_bank_ram: two-bank sf0/sf1 store; 1-wide stage-0 write, 4-wide stage-1 write, registered read of both arrays
// ports: clk/rstn/clr; we0,wb0,wa0,wd0 stage-0 write; we1,wb1,wa1,wd1 stage-1 beat write; re,rb,ra read -> rd0,rd1
module sf_bank_ram
  import fft_cbfp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        we0,
  input  bank_t       wb0,
  input  idx_t        wa0,
  input  sf_t         wd0,
  input  logic        we1,
  input  bank_t       wb1,
  input  beat_t       wa1,
  input  sf_t [3:0]   wd1,
  input  logic        re,
  input  bank_t       rb,
  input  idx_t        ra,
  output sf_t         rd0,
  output sf_t         rd1
);
  sf_t mem0 [2*NBLK];
  sf_t mem1 [2*NBLK];
  sf_t rd0_q, rd0_d, rd1_q, rd1_d;
  always_ff @(posedge clk) begin
    if (we0) mem0[{wb0, wa0}] <= wd0;
    if (we1) for (int k = 0; k < 4; k++) mem1[{wb1, wa1, 2'(k)}] <= wd1[k];
  end
  always_comb begin
    rd0_d = clr ? '0 : re ? mem0[{rb, ra}] : rd0_q;
    rd1_d = clr ? '0 : re ? mem1[{rb, ra}] : rd1_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  end
  assign rd0 = rd0_q;
  assign rd1 = rd1_q;
endmodule

// File: rtl/cbfp_sf_sched.sv
// cbfp_sf_sched: ping-pong scale-factor buffer releasing sf0+sf1 per block to the reorder stage
// ports: push0/sf0_in stage-0 push; push1/sf1_in stage-1 4-lane push; pop request;
//        frame_rdy, sf_valid/sf_total/sf_idx/frame_done read side; sticky ovf_err/udf_err
module cbfp_sf_sched
  import fft_cbfp_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       push0,
  input  sf_t        sf0_in,
  input  logic       push1,
  input  sf_t [3:0]  sf1_in,
  input  logic       pop,
  output logic       frame_rdy,
  output logic       sf_valid,
  output sf_total_t  sf_total,
  output idx_t       sf_idx,
  output logic       frame_done,
  output logic       ovf_err,
  output logic       udf_err
);
  idx_t cnt0_q, cnt0_d, rcnt_q, rcnt_d, idx_q, idx_d;
  beat_t cnt1_q, cnt1_d;
  bank_t wb0_q, wb0_d, wb1_q, wb1_d, rb_q, rb_d;
  logic [1:0] done0_q, done0_d, done1_q, done1_d;
  logic valid_q, valid_d, fdone_q, fdone_d, ovf_q, ovf_d, udf_q, udf_d;
  logic acc0, acc1, pop_ok, end0, end1, end_r;
  sf_t rd0, rd1;
  assign frame_rdy = done0_q[rb_q] & done1_q[rb_q];
  assign acc0 = push0 & ~done0_q[wb0_q];
  assign acc1 = push1 & ~done1_q[wb1_q];
  assign pop_ok = pop & frame_rdy;
  assign end0 = acc0 & (cnt0_q == idx_t'(NBLK-1));
  assign end1 = acc1 & (cnt1_q == beat_t'(BEATS1-1));
  assign end_r = pop_ok & (rcnt_q == idx_t'(NBLK-1));
  // a bank being released cannot also be completing a write, so clear-then-set order is safe
  always_comb begin
    cnt0_d = cnt0_q + idx_t'(acc0);
    cnt1_d = cnt1_q + beat_t'(acc1);
    rcnt_d = rcnt_q + idx_t'(pop_ok);
    wb0_d = wb0_q ^ end0;
    wb1_d = wb1_q ^ end1;
    rb_d = rb_q ^ end_r;
    done0_d = done0_q;
    done1_d = done1_q;
    if (end_r) begin
      done0_d[rb_q] = 1'b0;
      done1_d[rb_q] = 1'b0;
    end
    if (end0) done0_d[wb0_q] = 1'b1;
    if (end1) done1_d[wb1_q] = 1'b1;
    valid_d = pop_ok;
    idx_d = pop_ok ? rcnt_q : idx_q;
    fdone_d = end_r;
    ovf_d = ovf_q | (push0 & done0_q[wb0_q]) | (push1 & done1_q[wb1_q]);
    udf_d = udf_q | (pop & ~frame_rdy);
    if (clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
      rcnt_d = '0;
      wb0_d = '0;
      wb1_d = '0;
      rb_d = '0;
      done0_d = '0;
      done1_d = '0;
      valid_d = 1'b0;
      idx_d = '0;
      fdone_d = 1'b0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      rcnt_q <= '0;
      wb0_q <= '0;
      wb1_q <= '0;
      rb_q <= '0;
      done0_q <= '0;
      done1_q <= '0;
      valid_q <= 1'b0;
      idx_q <= '0;
      fdone_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      rcnt_q <= rcnt_d;
      wb0_q <= wb0_d;
      wb1_q <= wb1_d;
      rb_q <= rb_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      valid_q <= valid_d;
      idx_q <= idx_d;
      fdone_q <= fdone_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  sf_bank_ram u_ram (
    .clk(clk), .rstn(rstn), .clr(clr),
    .we0(acc0), .wb0(wb0_q), .wa0(cnt0_q), .wd0(sf0_in),
    .we1(acc1), .wb1(wb1_q), .wa1(cnt1_q), .wd1(sf1_in),
    .re(pop_ok), .rb(rb_q), .ra(rcnt_q),
    .rd0(rd0), .rd1(rd1)
  );
  assign sf_total = {1'b0, rd0} + {1'b0, rd1};
  assign sf_valid = valid_q;
  assign sf_idx = idx_q;
  assign frame_done = fdone_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
endmodule

// File: tb/tb_cbfp_sf_sched.sv
// tb_cbfp_sf_sched: table-driven frames with a scoreboard queue checked on every sf_valid
module tb_cbfp_sf_sched;
  import fft_cbfp_pkg::*;
  typedef struct { logic [4:0] s0; logic [4:0] s1; logic [5:0] tot; } vec_t;
  typedef struct { int idx; int tot; int last; } exp_t;
  logic clk = 0, rstn = 0, clr = 0, push0 = 0, push1 = 0, pop = 0;
  sf_t sf0_in = '0;
  sf_t [3:0] sf1_in = '0;
  logic frame_rdy, sf_valid, frame_done, ovf_err, udf_err;
  sf_total_t sf_total;
  idx_t sf_idx;
  vec_t tab [4][32];
  exp_t sbq [$];
  exp_t e;
  int n_pass = 0, n_tot = 0, n_done = 0;
  always #5 clk = ~clk;
  cbfp_sf_sched dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .push0(push0), .sf0_in(sf0_in), .push1(push1), .sf1_in(sf1_in), .pop(pop),
    .frame_rdy(frame_rdy), .sf_valid(sf_valid), .sf_total(sf_total), .sf_idx(sf_idx),
    .frame_done(frame_done), .ovf_err(ovf_err), .udf_err(udf_err)
  );
  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (sf_valid) begin
      if (sbq.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = sbq.pop_front();
        check("sf_idx", int'(sf_idx), e.idx);
        check("sf_total", int'(sf_total), e.tot);
        check("frame_done", int'(frame_done), e.last);
      end
    end else if (frame_done) check("done_without_valid", 1, 0);
  end
  function automatic logic [19:0] lanes(input int p, input int b);
    int bb = b % 8;
    return {tab[p][4*bb+3].s1, tab[p][4*bb+2].s1, tab[p][4*bb+1].s1, tab[p][4*bb].s1};
  endfunction
  task automatic cyc(input logic p0, input sf_t v0, input logic p1, input logic [19:0] v1, input logic pp, input logic c);
    push0 = p0; sf0_in = v0; push1 = p1; sf1_in = v1; pop = pp; clr = c;
    @(posedge clk); #1;
    push0 = 0; push1 = 0; pop = 0; clr = 0;
  endtask
  task automatic expect_blk(input int p, input int i);
    sbq.push_back('{i, int'(tab[p][i].tot), int'(i == 31)});
  endtask
  task automatic push_frame(input int p, input int rdy_before);
    for (int i = 0; i < 32; i++) begin
      if (i == 31 && rdy_before >= 0) check("frame_rdy_before_last", int'(frame_rdy), rdy_before);
      cyc(1, tab[p][i].s0, i < 8, lanes(p, i), 0, 0);
    end
  endtask
  task automatic pop_frame(input int p, input logic xp);
    for (int i = 0; i < 32; i++) begin
      expect_blk(p, i);
      cyc(xp && i == 31, 5'd17, 0, '0, 1, 0);
    end
  endtask
  task automatic stream(input int pa, input int pb);
    for (int i = 0; i < 32; i++) begin
      expect_blk(pa, i);
      cyc(1, tab[pb][i].s0, i < 8, lanes(pb, i), 1, 0);
    end
  endtask
  task automatic partial(input int p);
    for (int i = 0; i < 10; i++) cyc(1, tab[p][i].s0, i < 3, lanes(p, i), 0, 0);
  endtask
  task automatic zero_chk(input string tag);
    check({tag, "_frame_rdy"}, int'(frame_rdy), 0);
    check({tag, "_sf_valid"}, int'(sf_valid), 0);
    check({tag, "_sf_total"}, int'(sf_total), 0);
    check({tag, "_sf_idx"}, int'(sf_idx), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_ovf_err"}, int'(ovf_err), 0);
    check({tag, "_udf_err"}, int'(udf_err), 0);
  endtask
  task automatic do_reset(input string tag);
    rstn = 0; #2;
    check({tag, "_sbq_empty"}, sbq.size(), 0);
    zero_chk(tag);
    @(posedge clk); #1;
    rstn = 1;
  endtask
  task automatic idle_drain(input string tag);
    cyc(0, '0, 0, '0, 0, 0);
    check({tag, "_sbq_empty"}, sbq.size(), 0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      tab[0][i] = '{5'(i % 8), 5'd3, 6'(i % 8 + 3)};
      tab[1][i] = '{5'(31 - i), 5'(i), 6'd31};
      tab[2][i] = '{5'd31, 5'd31, 6'd62};
      tab[3][i] = '{5'(i), 5'((i * 7) % 32), 6'(i + (i * 7) % 32)};
    end
    #12;
    zero_chk("reset");
    @(posedge clk); #1;
    rstn = 1;
    cyc(0, '0, 0, '0, 1, 0);
    check("t3_udf_set", int'(udf_err), 1);
    check("t3_valid_low", int'(sf_valid), 0);
    push_frame(0, 0);
    check("t1_frame_rdy_rise", int'(frame_rdy), 1);
    pop_frame(0, 0);
    check("t1_frame_rdy_drop", int'(frame_rdy), 0);
    idle_drain("t1");
    check("t3_udf_sticky", int'(udf_err), 1);
    check("t1_ovf_clear", int'(ovf_err), 0);
    do_reset("t2");
    push_frame(1, -1);
    push_frame(2, -1);
    check("t2_ovf_before", int'(ovf_err), 0);
    cyc(1, 5'd9, 0, '0, 0, 0);
    check("t2_ovf_set", int'(ovf_err), 1);
    check("t2_frame_rdy", int'(frame_rdy), 1);
    pop_frame(1, 0);
    pop_frame(2, 0);
    idle_drain("t2");
    check("t2_frame_rdy_end", int'(frame_rdy), 0);
    do_reset("t4");
    n_done = 0;
    push_frame(3, 0);
    stream(3, 0);
    pop_frame(0, 0);
    idle_drain("t4");
    check("t4_done_pulses", n_done, 2);
    check("t4_ovf", int'(ovf_err), 0);
    check("t4_udf", int'(udf_err), 0);
    do_reset("t5");
    push_frame(1, 0);
    push_frame(2, 1);
    pop_frame(1, 1);
    check("t5_ovf_set", int'(ovf_err), 1);
    push_frame(3, -1);
    check("t5_frame_rdy", int'(frame_rdy), 1);
    pop_frame(2, 0);
    pop_frame(3, 0);
    idle_drain("t5");
    check("t5_udf", int'(udf_err), 0);
    do_reset("t6a_pre");
    push_frame(2, 0);
    pop_frame(2, 0);
    cyc(0, '0, 0, '0, 1, 0);
    partial(0);
    check("t6a_total_held", int'(sf_total), 62);
    check("t6a_udf_before", int'(udf_err), 1);
    do_reset("t6a");
    push_frame(1, 0);
    pop_frame(1, 0);
    idle_drain("t6a");
    push_frame(2, 0);
    pop_frame(2, 0);
    cyc(0, '0, 0, '0, 1, 0);
    partial(3);
    check("t6b_udf_before", int'(udf_err), 1);
    cyc(0, '0, 0, '0, 0, 1);
    zero_chk("t6b_clr");
    push_frame(3, 0);
    pop_frame(3, 0);
    idle_drain("t6b");
    check("t6b_ovf", int'(ovf_err), 0);
    check("t6b_udf", int'(udf_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/cbfp_sf_sched.md
Name: cbfp_sf_sched

Overview:
Scale-factor buffer and scheduler for the 512-point FFT CBFP chain.
- Collects stage-0 scale factors (one per beat) and stage-1 scale factors (four per beat) into two ping-pong frame banks.
- Releases each completed frame to the CBFP-2/reorder stage in order, one combined shift per pop.
- Detects overflow and underflow misuse of the shared scale-factor store.

Parameters:
SF_W, 5, width of a single scale factor
NBLK, 32, scale factors per frame per stage (32 blocks of 16 points)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
clr  in  1  synchronous flush; same effect as reset, applied at the clock edge
push0  in  1  stage-0 push strobe (cbfp0_mem_push)
sf0_in  in  SF_W  stage-0 scale factor
push1  in  1  stage-1 push strobe (cbfp1_mem_push)
sf1_in  in  4xSF_W  stage-1 factors, ordered [0]=1st_add, [1]=1st_sub, [2]=2nd_add, [3]=2nd_sub
pop  in  1  request for next combined factor from the reorder stage
frame_rdy  out  1  read bank holds a complete frame
sf_valid  out  1  sf_total and sf_idx are valid
sf_total  out  SF_W+1  sf0 + sf1 for the block at sf_idx (unsigned)
sf_idx  out  5  block index 0..31
frame_done  out  1  one-cycle pulse with the last sf_valid of a frame
ovf_err  out  1  sticky: a push was dropped
udf_err  out  1  sticky: a pop was issued without frame_rdy

Behaviour:
Clock and reset:
- One clock domain, clk.
- Reset is asynchronous and active-low (rstn).
- Reset and clr zero every counter, bank pointer, done flag and output. Both write pointers and the read pointer return to bank 0.

Storage:
- Per bank: sf0 array [NBLK] and sf1 array [NBLK], each SF_W wide.
- Per bank flags: done0 and done1.

Stage-0 writes (cnt0, 0..31, pointer wb0):
- Push is legal when done0[wb0] = 0. Write sf0[wb0][cnt0], then increment cnt0.
- At cnt0 = 31: set done0[wb0], toggle wb0, wrap cnt0 to 0.

Stage-1 writes (cnt1, 0..7, pointer wb1):
- Push is legal when done1[wb1] = 0. Write entries 4*cnt1 + k = sf1_in[k] for k = 0..3.
- At cnt1 = 7: set done1[wb1], toggle wb1, wrap cnt1 to 0.

Illegal pushes:
- A push to a bank whose done flag is set is dropped with no state change and sets ovf_err.
- push0 and push1 in the same cycle are independent and both legal.

frame_rdy:
- Combinational: done0[rb] & done1[rb].

Reads (rcnt, 0..31, pointer rb):
- Pop with frame_rdy = 1: next cycle sf_valid = 1, sf_idx = rcnt, sf_total = sf0[rb][rcnt] + sf1[rb][rcnt] (zero-extended, no saturation). Then rcnt increments.
- Pop latency is 1 cycle, fully pipelined; back-to-back pops give 32 consecutive sf_valid cycles.
- At rcnt = 31: clear done0[rb] and done1[rb], toggle rb, wrap rcnt. frame_done pulses in the same cycle as that final sf_valid.
- Pop with frame_rdy = 0: ignored and sets udf_err. sf_valid stays 0.
- When no pop is accepted, sf_valid = 0. sf_total and sf_idx hold their last values.

Same-cycle boundary cases:
- Bank release happens at the clock edge. A push evaluated in the same cycle as the final pop of its target bank sees the pre-edge flag and is dropped with ovf_err.
- Push completing a frame and pop in the same cycle: frame_rdy updates the next cycle, so that pop is judged against the old frame_rdy.

Error flags:
- ovf_err and udf_err are sticky until reset or clr.
- clr mid-frame discards partial frames, with no frame_done pulse.

Decomposition:
- Package fft_cbfp_pkg: SF_W, NBLK, BEATS1 = 8, sf_t, sf_total_t, and bank index type.
- One natural sub-module, sf_bank_ram: dual array, SF_W wide and 2*NBLK deep, with 1 write port for stage 0, 4-wide write port for stage 1, and 1 registered read port.
- Counters, flags and the error logic stay in cbfp_sf_sched.

Test Plan:
1. 32 push0 with sf0 = idx%8, 8 push1 with all four lanes = 3, then 32 back-to-back pops -> frame_rdy rises 1 cycle after the last push. sf_total = idx%8 + 3 for idx 0..31. frame_done coincides with sf_idx = 31. frame_rdy then drops.
2. Fill two full frames with no pops, then 1 extra push0 -> ovf_err = 1, the push is ignored, and both frames still read out intact in order bank0 then bank1.
3. Pop at reset with an empty store -> udf_err = 1, sf_valid stays 0, and rcnt is unchanged (the first later legal pop yields sf_idx = 0).
4. Interleaved streaming: frame N+1 pushes overlap frame N pops at one pop per cycle -> no errors. sf_idx sequence is 0..31 twice and exactly 2 frame_done pulses.
5. Final pop of bank0 in the same cycle as a push0 targeting bank0 -> push dropped and ovf_err = 1. A push0 one cycle later is accepted.
6. Assert rstn low after 10 push0 and 3 push1 -> all outputs 0. A subsequent full frame reads back correctly starting at sf_idx 0 with no stale data. Repeat the same test using clr.
